// File: rtl/cache_req_ctrl.sv
// Two-port round-robin request sequencer for a 2-way write-through data cache.
// Define CACHE_WRITE_ALLOCATE_EN to refill and fill the cache on write misses.
module cache_req_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req0_write,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WORD_W-1:0]  req0_wdata,
  output logic               req0_ready,
  output logic               req0_done,
  output logic [WORD_W-1:0]  req0_rdata,
  input  logic               req1_valid,
  input  logic               req1_write,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WORD_W-1:0]  req1_wdata,
  output logic               req1_ready,
  output logic               req1_done,
  output logic [WORD_W-1:0]  req1_rdata,
  output logic               cache_lookup,
  output logic               cache_write,
  output logic [ADDR_W-1:0]  cache_addr,
  output logic [WORD_W-1:0]  cache_wdata,
  input  logic               cache_hit,
  input  logic [WORD_W-1:0]  cache_rdata,
  output logic               cache_fill,
  output logic [BLOCK_W-1:0] cache_fill_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack
);

  localparam int unsigned ByteOffW = $clog2(WORD_W / 8);
  localparam int unsigned BlkOffW  = $clog2(BLOCK_W / 8);
  localparam int unsigned WselW    = BlkOffW - ByteOffW;

`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit AllocEn = 1'b1;
`else
  localparam bit AllocEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRefill,
    StFill,
    StWriteThru,
    StDone
  } state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                gnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rdata_q;

  logic                any_valid;
  logic                gnt;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WORD_W-1:0]   sel_wdata;
  logic [WselW-1:0]    wsel;
  logic [BLOCK_W-1:0]  merged;
  logic [WORD_W-1:0]   mem_word;
  logic [ADDR_W-1:0]   blk_addr;
  logic [ADDR_W-1:0]   word_addr;

  // Contested grant goes to the port that did not win last time.
  assign any_valid = req0_valid | req1_valid;
  assign gnt       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  assign req0_ready = rst_n & (state_q == StIdle) & any_valid & ~gnt;
  assign req1_ready = rst_n & (state_q == StIdle) & any_valid & gnt;

  assign sel_write = gnt ? req1_write : req0_write;
  assign sel_addr  = gnt ? req1_addr  : req0_addr;
  assign sel_wdata = gnt ? req1_wdata : req0_wdata;

  assign wsel      = addr_q[BlkOffW-1:ByteOffW];
  assign blk_addr  = {addr_q[ADDR_W-1:BlkOffW], {BlkOffW{1'b0}}};
  assign word_addr = {addr_q[ADDR_W-1:ByteOffW], {ByteOffW{1'b0}}};

  always_comb begin
    merged = mem_rdata;
    merged[wsel*WORD_W +: WORD_W] = wdata_q;
    mem_word = mem_rdata[wsel*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      last_grant_q    <= 1'b1;
      gnt_q           <= 1'b0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      req0_done       <= 1'b0;
      req1_done       <= 1'b0;
      req0_rdata      <= '0;
      req1_rdata      <= '0;
      cache_lookup    <= 1'b0;
      cache_write     <= 1'b0;
      cache_addr      <= '0;
      cache_wdata     <= '0;
      cache_fill      <= 1'b0;
      cache_fill_data <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      // Strobes and completion outputs are single-cycle unless re-asserted below.
      cache_lookup    <= 1'b0;
      cache_write     <= 1'b0;
      cache_addr      <= '0;
      cache_wdata     <= '0;
      cache_fill      <= 1'b0;
      cache_fill_data <= '0;
      req0_done       <= 1'b0;
      req1_done       <= 1'b0;
      req0_rdata      <= '0;
      req1_rdata      <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            gnt_q        <= gnt;
            last_grant_q <= gnt;
            wr_q         <= sel_write;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            cache_lookup <= 1'b1;
            cache_write  <= sel_write;
            cache_addr   <= sel_addr;
            cache_wdata  <= sel_wdata;
            state_q      <= StLookup;
          end
        end
        StLookup: begin
          if (!wr_q && cache_hit) begin
            req0_done <= ~gnt_q;
            req1_done <= gnt_q;
            if (gnt_q) req1_rdata <= cache_rdata;
            else       req0_rdata <= cache_rdata;
            state_q   <= StDone;
          end else if (!cache_hit && (!wr_q || AllocEn)) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= blk_addr;
            state_q  <= StRefill;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= wdata_q;
            state_q   <= StWriteThru;
          end
        end
        StRefill: begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            cache_fill      <= 1'b1;
            cache_addr      <= addr_q;
            cache_fill_data <= wr_q ? merged : mem_rdata;
            rdata_q         <= mem_word;
            state_q         <= StFill;
          end
        end
        StFill: begin
          if (wr_q) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= wdata_q;
            state_q   <= StWriteThru;
          end else begin
            req0_done <= ~gnt_q;
            req1_done <= gnt_q;
            if (gnt_q) req1_rdata <= rdata_q;
            else       req0_rdata <= rdata_q;
            state_q   <= StDone;
          end
        end
        StWriteThru: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req0_done <= ~gnt_q;
            req1_done <= gnt_q;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Randomized bench for cache_req_ctrl: acts as requesters, cache and memory, and checks
// every cycle against a transaction-timeline model derived from the latency rules.
module tb_cache_req_ctrl;

`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit AllocEn = 1'b1;
`else
  localparam bit AllocEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_write, req1_valid, req1_write;
  logic [9:0]   req0_addr, req1_addr;
  logic [31:0]  req0_wdata, req1_wdata;
  logic         req0_ready, req0_done, req1_ready, req1_done;
  logic [31:0]  req0_rdata, req1_rdata;
  logic         cache_lookup, cache_write, cache_hit, cache_fill;
  logic [9:0]   cache_addr;
  logic [31:0]  cache_wdata, cache_rdata;
  logic [127:0] cache_fill_data, mem_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;

  always #5 clk = ~clk;

  cache_req_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .cache_lookup(cache_lookup), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_fill(cache_fill), .cache_fill_data(cache_fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int failures = 0;

  // Requester side: a pending request is held until the model says it was accepted.
  logic        pend_v[2];
  logic        pend_w[2];
  logic [9:0]  pend_a[2];
  logic [31:0] pend_d[2];

  // Model: current transaction and its timeline (k = cycles since the accepting edge).
  logic         busy, lg, g_q;
  int           k, done_k, fill_k, ws;
  logic         t_w, t_hit, miss_path;
  int           t_l1, t_l2;
  logic [9:0]   t_a;
  logic [31:0]  t_d, t_crd;
  logic [127:0] t_blk;

  logic         force_plan, f_hit;
  int           f_l1, f_l2;
  logic [31:0]  f_crd;
  logic [127:0] f_blk;
  logic         gen_en, spur_en, cont_mode;

  int           obs_done_k, obs_done_port, obs_rises, done_cnt;
  logic [31:0]  obs_rdata, obs_wt_data;
  logic [9:0]   obs_first_maddr, obs_wt_addr;
  logic         obs_fill, obs_first_we, prev_mr;
  logic [127:0] obs_fill_data;
  int           grant_seq[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] blk_word(input logic [127:0] b, input int w);
    logic [127:0] t;
    t = b >> (32 * w);
    return t[31:0];
  endfunction

  function automatic logic [127:0] blk_merge(input logic [127:0] b, input int w,
                                             input logic [31:0] d);
    logic [127:0] m;
    m = 128'hFFFF_FFFF << (32 * w);
    return (b & ~m) | ({96'b0, d} << (32 * w));
  endfunction

  function automatic logic [9:0] rand_addr();
    logic [9:0] a;
    a = {8'($urandom_range(0, 255)), 2'b00};
    return a;
  endfunction

  task automatic drive_reqs();
    req0_valid = pend_v[0]; req0_write = pend_w[0]; req0_addr = pend_a[0];
    req0_wdata = pend_d[0];
    req1_valid = pend_v[1]; req1_write = pend_w[1]; req1_addr = pend_a[1];
    req1_wdata = pend_d[1];
  endtask

  task automatic set_req(input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    pend_v[p] = 1'b1; pend_w[p] = w; pend_a[p] = a; pend_d[p] = d;
  endtask

  task automatic model_reset();
    busy = 1'b0; lg = 1'b1; k = 0; prev_mr = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready0"}, req0_ready, 0);  chk({name, "_ready1"}, req1_ready, 0);
    chk({name, "_done0"}, req0_done, 0);    chk({name, "_done1"}, req1_done, 0);
    chk({name, "_rdata0"}, req0_rdata, 0);  chk({name, "_rdata1"}, req1_rdata, 0);
    chk({name, "_lookup"}, cache_lookup, 0); chk({name, "_cwrite"}, cache_write, 0);
    chk({name, "_caddr"}, cache_addr, 0);   chk({name, "_cwdata"}, cache_wdata, 0);
    chk({name, "_fill"}, cache_fill, 0);    chk({name, "_filldata"}, cache_fill_data, 0);
    chk({name, "_mreq"}, mem_req, 0);       chk({name, "_mwe"}, mem_we, 0);
    chk({name, "_maddr"}, mem_addr, 0);     chk({name, "_mwdata"}, mem_wdata, 0);
  endtask

  task automatic accept(input logic g);
    g_q = g; lg = g;
    t_w = pend_w[g]; t_a = pend_a[g]; t_d = pend_d[g];
    pend_v[g] = 1'b0;
    if (force_plan) begin
      t_hit = f_hit; t_l1 = f_l1; t_l2 = f_l2; t_crd = f_crd; t_blk = f_blk;
    end else begin
      t_hit = 1'($urandom_range(0, 1));
      t_l1 = $urandom_range(1, 5); t_l2 = $urandom_range(1, 5);
      t_crd = $urandom; t_blk = {$urandom, $urandom, $urandom, $urandom};
    end
    miss_path = !t_hit && (!t_w || AllocEn);
    fill_k = t_l1 + 2;
    ws = miss_path ? t_l1 + 3 : 2;
    done_k = t_w ? ws + t_l2 : (t_hit ? 2 : t_l1 + 3);
    obs_done_k = -1; obs_done_port = -1; obs_rises = 0; obs_fill = 1'b0;
    obs_rdata = '0; obs_fill_data = '0; obs_first_maddr = '0; obs_first_we = 1'b0;
    obs_wt_addr = '0; obs_wt_data = '0;
    busy = 1'b1; k = 1;
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic cycle();
    logic any, gg, e_rdy0, e_rdy1, e_lk, e_cw, e_fill, e_mr, e_we, e_done, ack;
    logic [9:0]   e_maddr;
    logic [31:0]  e_rd;
    logic [127:0] e_fd;
    for (int p = 0; p < 2; p++) begin
      if (!pend_v[p]) begin
        if (cont_mode) set_req(p, 1'b0, rand_addr(), $urandom);
        else if (gen_en && $urandom_range(0, 3) == 0)
          set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
    end
    drive_reqs();
    any = pend_v[0] | pend_v[1];
    gg = (pend_v[0] && pend_v[1]) ? ~lg : pend_v[1];
    e_rdy0 = !busy && any && !gg;
    e_rdy1 = !busy && any && gg;
    e_lk = 0; e_cw = 0; e_fill = 0; e_mr = 0; e_we = 0; e_done = 0; ack = 0;
    e_maddr = '0; e_rd = '0; e_fd = '0;
    if (busy) begin
      e_lk = (k == 1);
      e_cw = (k == 1) && t_w;
      e_fill = miss_path && (k == fill_k);
      e_fd = t_w ? blk_merge(t_blk, int'(t_a[3:2]), t_d) : t_blk;
      if (miss_path && k >= 2 && k <= t_l1 + 1) begin
        e_mr = 1; e_maddr = {t_a[9:4], 4'b0}; ack = (k == t_l1 + 1);
      end
      if (t_w && k >= ws && k < ws + t_l2) begin
        e_mr = 1; e_we = 1; e_maddr = {t_a[9:2], 2'b0}; ack = (k == ws + t_l2 - 1);
      end
      e_done = (k == done_k);
      e_rd = t_w ? 32'h0 : (t_hit ? t_crd : blk_word(t_blk, int'(t_a[3:2])));
    end
    cache_hit   = (busy && k == 1) ? t_hit : 1'($urandom_range(0, 1));
    cache_rdata = (busy && k == 1) ? t_crd : $urandom;
    mem_ack     = ack || (!e_mr && spur_en && $urandom_range(0, 3) == 0);
    mem_rdata   = ack ? t_blk : {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("req0_ready", req0_ready, e_rdy0);
    chk("req1_ready", req1_ready, e_rdy1);
    chk("cache_lookup", cache_lookup, e_lk);
    chk("cache_write", cache_write, e_cw);
    if (e_lk) begin
      chk("lookup_addr", cache_addr, t_a);
      chk("lookup_wdata", cache_wdata, t_d);
    end
    chk("cache_fill", cache_fill, e_fill);
    if (e_fill) begin
      chk("fill_addr", cache_addr, t_a);
      chk("fill_data", cache_fill_data, e_fd);
    end
    chk("mem_req", mem_req, e_mr);
    if (e_mr) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_maddr);
      if (e_we) chk("mem_wdata", mem_wdata, t_d);
    end
    chk("req0_done", req0_done, e_done && !g_q);
    chk("req1_done", req1_done, e_done && g_q);
    if (e_done) chk("done_rdata", g_q ? req1_rdata : req0_rdata, e_rd);
    if (cache_fill) begin obs_fill = 1; obs_fill_data = cache_fill_data; end
    if (mem_req && !prev_mr) begin
      obs_rises++;
      if (obs_rises == 1) begin obs_first_maddr = mem_addr; obs_first_we = mem_we; end
    end
    if (mem_req && mem_we) begin obs_wt_addr = mem_addr; obs_wt_data = mem_wdata; end
    prev_mr = mem_req;
    if (req0_done || req1_done) begin
      done_cnt++;
      obs_done_k = k;
      obs_done_port = req1_done ? 1 : 0;
      obs_rdata = req1_done ? req1_rdata : req0_rdata;
    end
    if (!busy) begin
      if (any) accept(gg);
    end else if (k == done_k) busy = 1'b0;
    else k++;
    @(negedge clk);
  endtask

  // Run until the next transaction has been accepted and completed.
  task automatic run_one(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin cycle(); n++; end
    while (busy && n < 200) begin cycle(); n++; end
    checks++;
    if (busy || n >= 200) begin
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle at %0t", name, $time);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    pend_v = '{1'b0, 1'b0}; pend_w = '{1'b0, 1'b0};
    pend_a = '{10'h0, 10'h0}; pend_d = '{32'h0, 32'h0};
    drive_reqs();
    cache_hit = 0; cache_rdata = '0; mem_ack = 0; mem_rdata = '0;
    force_plan = 1; f_hit = 0; f_l1 = 1; f_l2 = 1; f_crd = '0; f_blk = '0;
    gen_en = 0; spur_en = 0; cont_mode = 0; done_cnt = 0; g_q = 0;
    model_reset();

    // Reset with random inputs: every output is low.
    repeat (3) begin
      @(negedge clk);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_write = 1'($urandom); req1_write = 1'($urandom);
      req0_addr = 10'($urandom); req1_addr = 10'($urandom);
      req0_wdata = $urandom; req1_wdata = $urandom;
      cache_hit = 1'($urandom); mem_ack = 1'($urandom);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1 check_all_zero("reset");
    end
    @(negedge clk);
    drive_reqs(); mem_ack = 0;
    rst_n = 1'b1;
    cycle();

    // Read miss at 0x124 with three-cycle memory latency.
    set_req(0, 1'b0, 10'h124, 32'h0);
    drive_reqs();
    #1 chk("first_idle_ready0", req0_ready, 1);
    f_hit = 0; f_l1 = 3;
    f_blk = {32'hD, 32'hC, 32'hB, 32'hA};
    run_one("read_miss");
    chk("rm_mem_addr", obs_first_maddr, 10'h120);
    chk("rm_fill_data", obs_fill_data, 128'h0000000D_0000000C_0000000B_0000000A);
    chk("rm_rdata", obs_rdata, 32'hB);
    chk("rm_latency", obs_done_k, 6);

    // Same address hits.
    set_req(0, 1'b0, 10'h124, 32'h0);
    f_hit = 1; f_crd = 32'hCAFE;
    run_one("read_hit");
    chk("rh_rdata", obs_rdata, 32'hCAFE);
    chk("rh_latency", obs_done_k, 2);
    chk("rh_no_mem_req", obs_rises, 0);

    // Write miss from port 1.
    set_req(1, 1'b1, 10'h3F8, 32'hDEADBEEF);
    f_hit = 0; f_l1 = 2; f_l2 = 2;
    f_blk = 128'h33333333_22222222_11111111_00000000;
    run_one("write_miss");
    chk("wm_port", obs_done_port, 1);
    chk("wm_rdata", obs_rdata, 32'h0);
    chk("wm_wt_addr", obs_wt_addr, 10'h3F8);
    chk("wm_wt_data", obs_wt_data, 32'hDEADBEEF);
`ifdef CACHE_WRITE_ALLOCATE_EN
    chk("wm_rises", obs_rises, 2);
    chk("wm_refill_addr", obs_first_maddr, 10'h3F0);
    chk("wm_fill_data", obs_fill_data, 128'h33333333_DEADBEEF_11111111_00000000);
    chk("wm_latency", obs_done_k, 7);
`else
    chk("wm_rises", obs_rises, 1);
    chk("wm_first_we", obs_first_we, 1);
    chk("wm_no_fill", obs_fill, 0);
    chk("wm_latency", obs_done_k, 4);
`endif

    // Both ports valid continuously with read hits: grants alternate.
    cont_mode = 1; f_hit = 1; f_crd = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      run_one("contention");
      grant_seq[i] = obs_done_port;
    end
    chk("grant0", grant_seq[0], 0);
    chk("grant1", grant_seq[1], 1);
    chk("grant2", grant_seq[2], 0);
    chk("grant3", grant_seq[3], 1);
    cont_mode = 0;
    n = 0;
    while ((pend_v[0] || pend_v[1]) && n < 4) begin run_one("drain"); n++; end

    // Reset in the middle of a refill.
    set_req(0, 1'b0, 10'h1A4, 32'h0);
    f_hit = 0; f_l1 = 10;
    n = 0;
    while (!(busy && k == 3) && n < 50) begin cycle(); n++; end
    #2 rst_n = 1'b0;
    #1 chk("abort_mem_req", mem_req, 0);
    check_all_zero("abort");
    model_reset();
    set_req(0, 1'b0, 10'h1A4, 32'h0);
    drive_reqs();
    cache_hit = 1; mem_ack = 1;
    @(negedge clk);
    #1 check_all_zero("abort_hold");
    mem_ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    f_hit = 1; f_crd = 32'h55AA;
    run_one("after_abort");
    chk("aa_port", obs_done_port, 0);
    chk("aa_rdata", obs_rdata, 32'h55AA);
    chk("aa_latency", obs_done_k, 2);

    // Spurious acks while idle, then an ack in the same cycle mem_req rises.
    spur_en = 1;
    repeat (6) cycle();
    spur_en = 0;
    set_req(0, 1'b0, 10'h2A8, 32'h0);
    f_hit = 0; f_l1 = 1;
    f_blk = 128'h44444444_33333333_22222222_11111111;
    run_one("zero_lat");
    chk("zl_latency", obs_done_k, 4);
    chk("zl_rdata", obs_rdata, 32'h33333333);

    // Random traffic.
    force_plan = 0; gen_en = 1; spur_en = 1;
    repeat (3000) cycle();
    gen_en = 0;
    n = 0;
    while ((busy || pend_v[0] || pend_v[1]) && n < 500) begin cycle(); n++; end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL random_drain actual=busy required=idle at %0t", $time);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
